// File: rtl/window_line_buffer.sv
// KxK sliding-window generator: K-1 line delays feed a KxK tap array; windows are registered out with row/col, centre tap and frame framing.
// Optional build macro WIN_STRIDE2_EN: emit only windows with even win_row and win_col.
module window_line_buffer #(
    parameter int DATA_W = 8,
    parameter int K      = 7,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic                    in_sof,
    input  logic [DATA_W-1:0]       in_data,
    output logic                    win_valid,
    output logic [K*K*DATA_W-1:0]   win_data,
    output logic [$clog2(IMG_H)-1:0] win_row,
    output logic [$clog2(IMG_W)-1:0] win_col,
    output logic [DATA_W-1:0]       center_data,
    output logic                    frame_done
);
    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);
    localparam int CT = (K - 1) / 2;
    localparam logic [RW-1:0] ROW_FIRST = RW'(K - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(K - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);

    logic [DATA_W-1:0] line_mem [K-1][IMG_W];
    logic [DATA_W-1:0] taps     [K][K];
    logic [DATA_W-1:0] taps_nxt [K][K];
    logic [DATA_W-1:0] src      [K];
    logic [K*K*DATA_W-1:0] win_nxt;

    logic [RW-1:0] row, cur_row, win_row_nxt;
    logic [CW-1:0] col, cur_col, win_col_nxt;
    logic          at_win, emit, at_last;

    // Row K-1 is the live pixel; each older row comes from one more line delay.
    always_comb begin
        src[K-1] = in_data;
        for (int j = 0; j < K - 1; j++)
            src[K-2-j] = line_mem[j][IMG_W-1];
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++)
                taps_nxt[r][c] = taps[r][c+1];
            taps_nxt[r][K-1] = src[r];
        end
        win_nxt = '0;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                win_nxt[(K*K-1-(r*K+c))*DATA_W +: DATA_W] = taps_nxt[r][c];
    end

    // Storage is never reset: a window is only emitted once it has been refilled.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            line_mem[0][0] <= in_data;
            for (int j = 1; j < K - 1; j++)
                line_mem[j][0] <= line_mem[j-1][IMG_W-1];
            for (int j = 0; j < K - 1; j++)
                for (int i = 1; i < IMG_W; i++)
                    line_mem[j][i] <= line_mem[j][i-1];
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++)
                    taps[r][c] <= taps_nxt[r][c];
        end
    end

    // in_sof overrides the counters so the qualified pixel is (0,0).
    always_comb begin
        cur_row     = in_sof ? '0 : row;
        cur_col     = in_sof ? '0 : col;
        at_win      = (cur_row >= ROW_FIRST) && (cur_col >= COL_FIRST);
        at_last     = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
        win_row_nxt = cur_row - ROW_FIRST;
        win_col_nxt = cur_col - COL_FIRST;
`ifdef WIN_STRIDE2_EN
        emit = at_win && !win_row_nxt[0] && !win_col_nxt[0];
`else
        emit = at_win;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row         <= '0;
            col         <= '0;
            win_valid   <= 1'b0;
            frame_done  <= 1'b0;
            win_data    <= '0;
            center_data <= '0;
            win_row     <= '0;
            win_col     <= '0;
        end else begin
            win_valid  <= in_valid && emit;
            frame_done <= in_valid && at_last;
            if (in_valid) begin
                if (cur_col == COL_LAST) begin
                    col <= '0;
                    row <= (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
                end else begin
                    col <= cur_col + 1'b1;
                    row <= cur_row;
                end
                if (emit) begin
                    win_data    <= win_nxt;
                    center_data <= taps_nxt[CT][CT];
                    win_row     <= win_row_nxt;
                    win_col     <= win_col_nxt;
                end
            end
        end
    end
endmodule

// File: doc/window_line_buffer.md
Name: window_line_buffer

Overview:
Parametrised KxK sliding-window generator for the NPU convolution front end. It accepts a raster-scan pixel stream, holds K-1 image lines in delay lines, and presents a full KxK window every time a pixel completes a window. Unlike the fixed 7x7 stage, it adds qualified shifting, row/column tracking, a window-valid flag, frame framing and a centre-pixel tap. It sits between the input pixel source and the MAC array.

Parameters:
DATA_W, 8, pixel width in bits
K, 7, window side; odd, 3..15
IMG_W, 28, pixels per line; must be >= K
IMG_H, 28, lines per frame; must be >= K

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  in_data is a valid pixel this cycle
in_sof  in  1  start of frame; qualifies the in_valid pixel as (0,0)
in_data  in  DATA_W  pixel, raster order
win_valid  out  1  win_data holds a complete window, one-cycle pulse per window
win_data  out  K*K*DATA_W  window, row-major: MSB slice = oldest row, leftmost column; LSB slice = newest pixel
win_row  out  $clog2(IMG_H)  output row index = pixel_row-(K-1)
win_col  out  $clog2(IMG_W)  output column index = pixel_col-(K-1)
center_data  out  DATA_W  window element at row (K-1)/2, col (K-1)/2
frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted

Behaviour:
- Reset (async, rst=1): win_valid=0, frame_done=0, win_data=0, center_data=0, win_row=0, win_col=0, col/row counters=0. Line-buffer storage need not be cleared; validity never depends on it.
- Storage: K-1 line delays of IMG_W entries each, chained; K shift registers of K taps each. Every register advances only on in_valid=1; idle cycles hold all state (no drift).
- Counters: col counts 0..IMG_W-1 per accepted pixel; on wrap col=0, row+1; row wraps IMG_H-1 -> 0.
- in_sof with in_valid: the pixel is (0,0), counters are forced so the next pixel is (0,1). in_sof without in_valid is ignored.
- Window output registered: on the cycle after accepting pixel (r,c) with r>=K-1 and c>=K-1, win_valid=1 and win_data/center_data/win_row/win_col are updated together. Otherwise win_valid=0; data outputs hold the last window.
- Latency: 1 clk from the accepting edge to win_valid. Windows per frame: (IMG_W-K+1)*(IMG_H-K+1).
- Line-boundary columns c<K-1 never produce windows, so windows never straddle lines.
- frame_done: pulses 1 cycle after pixel (IMG_H-1, IMG_W-1) is accepted, coincident with the last win_valid.
- Reset mid-frame: all outputs return to reset values immediately; the next pixel is treated as (0,0) whether or not in_sof is asserted.
- No backpressure: the consumer must accept a window every cycle.

Optional Feature:
WIN_STRIDE2_EN: when defined, win_valid is additionally gated so that it asserts only when win_row and win_col are both even (stride 2). win_row/win_col still report the stride-1 indices. Windows per frame = ceil((IMG_W-K+1)/2)*ceil((IMG_H-K+1)/2). When undefined, stride 1 as above.

Test Plan:
K=3, IMG_W=5, IMG_H=4, pixel=row*16+col, in_valid continuous from in_sof -> first win_valid 1 clk after pixel 0x22; win_data = 00,01,02,10,11,12,20,21,22; center_data=0x11; win_row=0, win_col=0; 6 windows total; last window is win_row=1, win_col=2, with frame_done in the same cycle.
Same frame with 0-3 random idle cycles between pixels -> identical window sequence, values and indices; no window emitted during idle cycles.
Two back-to-back frames, second frame pixels +0x80 -> second frame first window = 80,81,82,90,91,92,A0,A1,A2; no window formed from mixed-frame pixels ahead of (2,2).
in_sof reasserted at pixel (1,3) of a frame -> counters restart; first window follows the 13th pixel after in_sof.
rst pulsed after 8 pixels -> win_valid=0 and win_data=0 immediately; a restart without in_sof produces a correct frame.
WIN_STRIDE2_EN defined, continuous frame -> exactly 2 windows, at (win_row,win_col)=(0,0) and (0,2), with centres 0x11 and 0x13.
